qam_fir_share_ctrl: RTL

Time-multiplexing controller that shares one 2-channel interleaved FIR compiler instance between the I and Q demodulator outputs, replacing the two per-channel FIR instances in the receive path. It buffers incoming I/Q pairs, feeds the shared FIR strictly I-then-Q over an AXI-Stream handshake, and re-pairs the filtered results into aligned `filter_i`/`filter_q` outputs. It sits between the demultiplier stage and the symbol decision logic.

---
 rtl/qam_fir_share_ctrl_if.sv | 28 ++
 rtl/qam_fir_share_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/qam_fir_share_ctrl_if.sv
// AXI-Stream bus between the I/Q share controller and the shared 2-channel FIR.
// master = controller side, slave = FIR side.
interface qam_fir_share_ctrl_if #(
    parameter int FIR_IN_W = 24,
    parameter int OUT_W    = 32
);
    logic                fir_s_tvalid;
    logic                fir_s_tready;
    logic [FIR_IN_W-1:0] fir_s_tdata;
    logic                fir_m_tvalid;
    logic [OUT_W-1:0]    fir_m_tdata;

    modport master (
        output fir_s_tvalid,
        output fir_s_tdata,
        input  fir_s_tready,
        input  fir_m_tvalid,
        input  fir_m_tdata
    );

    modport slave (
        input  fir_s_tvalid,
        input  fir_s_tdata,
        output fir_s_tready,
        output fir_m_tvalid,
        output fir_m_tdata
    );
endinterface

// File: rtl/qam_fir_share_ctrl.sv
// Shares one 2-channel interleaved FIR between I and Q: pair FIFO, I-then-Q feeder, output re-pairing.
// Optional: QAM_FIR_SHARE_STATS_EN enables the saturating drop_count.
module qam_fir_share_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int IN_W       = 18,
    parameter int FIR_IN_W   = 24,
    parameter int OUT_W      = 32
) (
    input  logic                  axi_clk,
    input  logic                  axi_rst,
    input  logic                  demult_valid,
    input  logic [IN_W-1:0]       demult_i,
    input  logic [IN_W-1:0]       demult_q,
    qam_fir_share_ctrl_if.master  fir,
    output logic                  filter_ivalid,
    output logic [OUT_W-1:0]      filter_i,
    output logic                  filter_qvalid,
    output logic [OUT_W-1:0]      filter_q,
    output logic                  overflow,
    output logic [15:0]           drop_count
);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEND_I = 2'd1;
    localparam logic [1:0] SEND_Q = 2'd2;

    function automatic logic [FIR_IN_W-1:0] sext(input logic [IN_W-1:0] x);
        return FIR_IN_W'($signed(x));
    endfunction

    // pair FIFO
    logic [IN_W-1:0] mem_i [FIFO_DEPTH];
    logic [IN_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr, count;
    logic [AW-1:0]   rd_nidx;
    logic            empty, full, push, drop, pop;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push    = demult_valid && !full;
    assign drop    = demult_valid && full;
    assign rd_nidx = rd_ptr[AW-1:0] + AW'(1);

    always_ff @(posedge axi_clk) begin
        if (push) begin
            mem_i[wr_ptr[AW-1:0]] <= demult_i;
            mem_q[wr_ptr[AW-1:0]] <= demult_q;
        end
    end

    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // feed FSM
    logic [1:0]          state;
    logic                s_tvalid;
    logic [FIR_IN_W-1:0] s_tdata;
    logic                s_xfer, has_next;
    logic [IN_W-1:0]     next_i;

    assign s_xfer = s_tvalid && fir.fir_s_tready;
    assign pop    = (state == SEND_Q) && s_xfer;
    // A pair written in the same cycle as the pop keeps the stream gap-free;
    // its I sample is not in memory yet, so take it straight from the input.
    assign has_next = (count > (AW+1)'(1)) || push;
    assign next_i   = (count > (AW+1)'(1)) ? mem_i[rd_nidx] : demult_i;

    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            state    <= IDLE;
            s_tvalid <= 1'b0;
            s_tdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) state <= SEND_I;
                end
                SEND_I: begin
                    if (!s_tvalid) begin
                        s_tvalid <= 1'b1;
                        s_tdata  <= sext(mem_i[rd_ptr[AW-1:0]]);
                    end else if (fir.fir_s_tready) begin
                        s_tdata <= sext(mem_q[rd_ptr[AW-1:0]]);
                        state   <= SEND_Q;
                    end
                end
                SEND_Q: begin
                    if (fir.fir_s_tready) begin
                        if (has_next) begin
                            s_tdata <= sext(next_i);
                            state   <= SEND_I;
                        end else begin
                            s_tvalid <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                default: begin
                    s_tvalid <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign fir.fir_s_tvalid = s_tvalid;
    assign fir.fir_s_tdata  = s_tdata;

    // re-pairing: FIR reset tracks ours, so phase 0 is always channel I
    logic             phase;
    logic [OUT_W-1:0] i_hold;
    logic             f_valid;

    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            phase    <= 1'b0;
            i_hold   <= '0;
            f_valid  <= 1'b0;
            filter_i <= '0;
            filter_q <= '0;
        end else begin
            f_valid <= 1'b0;
            if (fir.fir_m_tvalid) begin
                phase <= ~phase;
                if (!phase) begin
                    i_hold <= fir.fir_m_tdata;
                end else begin
                    filter_i <= i_hold;
                    filter_q <= fir.fir_m_tdata;
                    f_valid  <= 1'b1;
                end
            end
        end
    end

    assign filter_ivalid = f_valid;
    assign filter_qvalid = f_valid;

    always_ff @(posedge axi_clk) begin
        if (axi_rst)   overflow <= 1'b0;
        else if (drop) overflow <= 1'b1;
    end

`ifdef QAM_FIR_SHARE_STATS_EN
    logic [15:0] drop_cnt;

    always_ff @(posedge axi_clk) begin
        if (axi_rst)
            drop_cnt <= '0;
        else if (drop && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
    end

    assign drop_count = drop_cnt;
`else
    assign drop_count = '0;
`endif

endmodule
